// File: rtl/mant_div_pkg.sv
// Shared FPU definitions: mantissa width and the sequential divider state encoding.
package mant_div_pkg;

    localparam int unsigned default_width = 24;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_state_t;

endpackage

// File: rtl/mant_div.sv
// Restoring mantissa divider: one quotient bit per cycle, MSB first, width+1 bits total.
// Divide counterpart of the combinational mantissa multiplier in the FPU datapath.
module mant_div
    import mant_div_pkg::*;
#(
    parameter int width = default_width
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic             Start,
    input  logic [width-1:0] Operand1,
    input  logic [width-1:0] Operand2,
    output logic             Busy,
    output logic             Done,
    output logic [width:0]   Quotient,
    output logic             Sticky,
    output logic             DivByZero,
    output fsm_state_t       fsm_state
);

    // Handshake: Start is taken only while Busy=0 (IDLE); Done pulses for one cycle
    // with Busy still high, and the results then hold until the next accepted Start.

    localparam int cw = $clog2(width + 1);

    fsm_state_t       state;
    logic [width-1:0] divisor;
    logic [width:0]   rem;
    logic [cw-1:0]    count;
    logic [width:0]   diff;
    logic             qbit;

    always_comb begin
        qbit = (rem >= {1'b0, divisor});
        diff = qbit ? (rem - {1'b0, divisor}) : rem;
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state     <= IDLE;
            divisor   <= '0;
            rem       <= '0;
            count     <= '0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Quotient  <= '0;
            Sticky    <= 1'b0;
            DivByZero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    Done <= 1'b0;
                    if (Start) begin
                        divisor <= Operand2;
                        Busy    <= 1'b1;
                        Sticky  <= 1'b0;
                        if (Operand2 == '0) begin
                            // No iterations needed: report saturated quotient straight away.
                            state     <= DONE;
                            Done      <= 1'b1;
                            Quotient  <= '1;
                            DivByZero <= 1'b1;
                            rem       <= '0;
                            count     <= '0;
                        end else begin
                            state     <= RUN;
                            Quotient  <= '0;
                            DivByZero <= 1'b0;
                            rem       <= {1'b0, Operand1};
                            count     <= cw'(width);
                        end
                    end
                end
                RUN: begin
                    Quotient <= {Quotient[width-1:0], qbit};
                    rem      <= {diff[width-1:0], 1'b0};
                    count    <= count - 1'b1;
                    if (count == '0) begin
                        state  <= DONE;
                        Done   <= 1'b1;
                        Sticky <= (diff != '0);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    Done  <= 1'b0;
                    Busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    Done  <= 1'b0;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

    assign fsm_state = state;

endmodule

// File: tb/tb_mant_div.sv
// Scoreboard bench for mant_div: driver pushes model results, negedge monitor pops on Done.
module tb_mant_div;
    import mant_div_pkg::*;

    localparam int W  = 24;
    localparam int EW = 32 + 2 + W + 1;

    logic           CLK = 1'b0;
    logic           RESETn = 1'b0;
    logic           Start = 1'b0;
    logic [W-1:0]   Operand1 = '0;
    logic [W-1:0]   Operand2 = '0;
    logic           Busy;
    logic           Done;
    logic [W:0]     Quotient;
    logic           Sticky;
    logic           DivByZero;
    fsm_state_t     fsm_state;

    mant_div #(.width(W)) dut (
        .CLK(CLK),
        .RESETn(RESETn),
        .Start(Start),
        .Operand1(Operand1),
        .Operand2(Operand2),
        .Busy(Busy),
        .Done(Done),
        .Quotient(Quotient),
        .Sticky(Sticky),
        .DivByZero(DivByZero),
        .fsm_state(fsm_state)
    );

    always #5 CLK = ~CLK;

    int unsigned cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] last_e = '0;
    bit            have_last = 1'b0;
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer division of op1*2^W by op2.
    task automatic push_expect(input logic [W-1:0] op1, input logic [W-1:0] op2,
                               input int unsigned acc);
        longint unsigned num, den;
        logic [W:0]      q;
        logic            st, dz;
        int unsigned     dc;
        if (op2 == '0) begin
            q = '1; st = 1'b0; dz = 1'b1; dc = acc;
        end else begin
            num = longint'(op1) << W;
            den = longint'(op2);
            q   = (W+1)'(num / den);
            st  = (num % den) != 0;
            dz  = 1'b0;
            dc  = acc + W + 1;
        end
        exp_q.push_back({dc, dz, st, q});
    endtask

    always @(negedge CLK) begin
        logic [EW-1:0] e;
        if (RESETn) begin
            if (Done) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: got Done=1 expected no Done (cycle %0d)", cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_cycle", 64'(cyc), 64'(e[EW-1:W+3]));
                    chk("quotient", 64'(Quotient), 64'(e[W:0]));
                    chk("sticky", 64'(Sticky), 64'(e[W+1]));
                    chk("div_by_zero", 64'(DivByZero), 64'(e[W+2]));
                    chk("busy_at_done", 64'(Busy), 64'd1);
                    last_e = e;
                    have_last = 1'b1;
                end
            end else if (exp_q.size() > 0 && cyc > exp_q[0][EW-1:W+3]) begin
                e = exp_q.pop_front();
                checks++; errors++;
                $display("FAIL done_timeout: got no Done expected Done at cycle %0d", e[EW-1:W+3]);
            end
        end
    end

    task automatic wait_idle();
        int guard = 0;
        while (Busy && guard < 200) begin
            @(negedge CLK);
            guard++;
        end
        if (Busy) begin
            checks++; errors++;
            $display("FAIL idle_timeout: got Busy=1 expected Busy=0");
        end
    endtask

    task automatic do_div(input logic [W-1:0] op1, input logic [W-1:0] op2);
        wait_idle();
        if (have_last) begin
            chk("held_quotient", 64'(Quotient), 64'(last_e[W:0]));
            chk("held_sticky", 64'(Sticky), 64'(last_e[W+1]));
            chk("held_dbz", 64'(DivByZero), 64'(last_e[W+2]));
        end
        Operand1 = op1;
        Operand2 = op2;
        Start = 1'b1;
        push_expect(op1, op2, cyc + 1);
        @(negedge CLK);
        Start = 1'b0;
        Operand1 = W'($urandom);
        Operand2 = W'($urandom);
    endtask

    function automatic logic [W-1:0] rand_norm();
        return {1'b1, (W-1)'($urandom)};
    endfunction

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_busy"}, 64'(Busy), 64'd0);
        chk({tag, "_done"}, 64'(Done), 64'd0);
        chk({tag, "_quotient"}, 64'(Quotient), 64'd0);
        chk({tag, "_sticky"}, 64'(Sticky), 64'd0);
        chk({tag, "_dbz"}, 64'(DivByZero), 64'd0);
        chk({tag, "_state"}, 64'(fsm_state), 64'(IDLE));
    endtask

    initial begin
        logic [W-1:0] a, b;
        int guard;

        RESETn = 1'b0;
        repeat (3) @(negedge CLK);
        check_zero_outputs("reset");
        RESETn = 1'b1;
        repeat (2) @(negedge CLK);
        check_zero_outputs("post_reset_idle");

        do_div(24'h800000, 24'h800000);
        do_div(24'h800000, 24'hC00000);
        do_div(24'hFFFFFF, 24'h800000);
        do_div(24'hC00000, 24'h800000);
        do_div(24'h9ABCDE, 24'h000000);
        do_div(24'h800000, 24'hFFFFFF);

        for (int i = 0; i < 40; i++) begin
            a = rand_norm();
            b = ($urandom_range(0, 9) == 0) ? '0 : rand_norm();
            do_div(a, b);
        end
        wait_idle();
        repeat (2) @(negedge CLK);

        // Abort a division in flight; no Done may follow.
        do_div(rand_norm(), rand_norm());
        repeat (10) @(negedge CLK);
        #2 RESETn = 1'b0;
        #1 check_zero_outputs("mid_run_reset");
        exp_q.delete();
        last_e = '0;
        have_last = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        RESETn = 1'b1;
        repeat (W + 6) @(negedge CLK);
        check_zero_outputs("no_start_after_reset");

        // Start held high: accepts only in IDLE, back-to-back after DONE.
        a = rand_norm();
        b = rand_norm();
        Operand1 = a;
        Operand2 = b;
        Start = 1'b1;
        push_expect(a, b, cyc + 1);
        push_expect(a, b, cyc + 1 + W + 3);
        repeat (2 * (W + 3)) @(negedge CLK);
        Start = 1'b0;

        do_div(rand_norm(), '0);
        do_div(rand_norm(), rand_norm());

        guard = 0;
        while (exp_q.size() > 0 && guard < 200) begin
            @(negedge CLK);
            guard++;
        end
        if (exp_q.size() > 0) begin
            checks++; errors++;
            $display("FAIL drain: got %0d pending results expected 0", exp_q.size());
        end
        repeat (5) @(negedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mant_div.md
MANT_DIV -- requirements
Module: mant_div

Interface
REQ-001 SHALL have parameter: width, 24, mantissa width in bits (hidden bit included).
REQ-002 SHALL have port: CLK  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: RESETn  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port: Start  input  1  request pulse; sampled only in IDLE.
REQ-005 SHALL have port: Operand1  input  width  dividend mantissa (normalised, MSB=1).
REQ-006 SHALL have port: Operand2  input  width  divisor mantissa (normalised, MSB=1).
REQ-007 SHALL have port: Busy  output  1  high while a division is in progress.
REQ-008 SHALL have port: Done  output  1  one-cycle pulse; results valid.
REQ-009 SHALL have port: Quotient  output  width+1  floor(Operand1*2^width / Operand2).
REQ-010 SHALL have port: Sticky  output  1  high when the final remainder is non-zero.
REQ-011 SHALL have port: DivByZero  output  1  high when Operand2 was zero at capture.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-013 SHALL, in IDLE with Start=1, capture Operand1/Operand2, load remainder = {1'b0, Operand1}, iteration counter = width, and go to RUN.
REQ-014 SHALL ignore Start in RUN and DONE; operand changes after capture have no effect.
REQ-015 SHALL compute one quotient bit per RUN cycle, MSB first (weight 2^width down to 2^0), restoring: bit = (rem >= divisor); if bit then rem -= divisor; rem <<= 1.
REQ-016 SHALL hold the remainder in width+1 bits; normalised operands guarantee no overflow.
REQ-017 SHALL spend exactly width+1 cycles in RUN, then 1 cycle in DONE, then return to IDLE.
REQ-018 SHALL give latency: Start accepted at edge k -> Done=1 in the cycle after edge k+width+1 (i.e. width+2 edges after acceptance).
REQ-019 SHALL assert Busy in RUN and DONE, deassert in IDLE; Done=1 only in DONE.
REQ-020 SHALL hold Quotient, Sticky, DivByZero stable from DONE until the next accepted Start.
REQ-021 SHALL accept a new Start in the IDLE cycle immediately following DONE (back-to-back throughput width+3 cycles).
REQ-022 SHALL, when Operand2 = 0 at capture, skip RUN: go IDLE->DONE, Quotient = all ones, Sticky = 0, DivByZero = 1.
REQ-023 SHALL produce results undefined but non-hanging for non-normalised non-zero operands (quotient truncated to width+1 bits).

Reset
REQ-024 SHALL, on RESETn=0 at any time including mid-RUN, asynchronously force state IDLE, Busy=0, Done=0, Quotient=0, Sticky=0, DivByZero=0, counter=0, remainder=0.
REQ-025 SHALL start no division until RESETn is high and a Start is sampled in IDLE.

Structure
REQ-026 SHALL place FSM state encoding (IDLE, RUN, DONE) and the default width in a shared FPU package used by the FPU datapath.
REQ-027 SHALL be a single module; the compare/subtract step is an inline datapath, no sub-module.
REQ-028 SHALL be the divide counterpart of the combinational mantissa multiplier in the single-cycle FPU, plugged into the same mantissa datapath.

Verification (width=24)
REQ-029 SHALL check Operand1=0x800000, Operand2=0x800000, Start -> Done after 26 edges, Quotient=0x1000000, Sticky=0, DivByZero=0.
REQ-030 SHALL check Operand1=0x800000, Operand2=0xC00000 -> Quotient=0x0AAAAAA, Sticky=1.
REQ-031 SHALL check Operand1=0xFFFFFF, Operand2=0x800000 -> Quotient=0x1FFFFFE, Sticky=0; Operand1=0xC00000, Operand2=0x800000 -> 0x1800000.
REQ-032 SHALL check Operand2=0 -> Done on 2nd edge after Start, Quotient=0x1FFFFFF, DivByZero=1, Sticky=0.
REQ-033 SHALL check RESETn pulsed low mid-RUN -> Busy/Done/outputs 0 immediately, no Done; Start held high during RUN/DONE -> exactly one Done per accepted Start, with back-to-back Start accepted in the cycle after DONE.
